cordic_quadrant_post: RTL and testbench
=======================================

Name: cordic_quadrant_post

Overview:
Downstream neighbour of the pipelined CORDIC core.
- The core only produces quadrant-I results. Upstream argument reduction folds each request into quadrant I and pushes a 2-bit quadrant tag here when it issues the core start.
- This block queues the tags in order and pairs each tag with the core result when the core signals done.
- It un-folds x/y/angle back to the full circle and presents the result on a valid/ready output register.

Parameters:
- BIT_WIDTH, 32, width of core x/y/angle data. Angle units: 2^BIT_WIDTH = pi.
- TAG_DEPTH, 16, tag FIFO depth; must be a power of two, >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- tag_push  input  1  push tag_quadrant (one per core start)
- tag_quadrant  input  2  quadrant of request: 0..3 = I..IV
- tag_full  output  1  FIFO holds TAG_DEPTH tags
- tag_count  output  $clog2(TAG_DEPTH)+1  tags queued
- core_done  input  1  core result valid this cycle
- core_x  input  BIT_WIDTH  signed core x
- core_y  input  BIT_WIDTH  signed core y
- core_angle  input  BIT_WIDTH  signed core angle
- out_valid  output  1  result held
- out_ready  input  1  downstream accepts
- out_x  output  BIT_WIDTH  signed unfolded x
- out_y  output  BIT_WIDTH  signed unfolded y
- out_angle  output  BIT_WIDTH+1  signed full-turn angle (2^(BIT_WIDTH+1) = 2*pi)
- out_quadrant  output  2  tag used
- err_tag_overflow  output  1  sticky: push dropped
- err_underrun  output  1  sticky: done with no tag
- err_overrun  output  1  sticky: result dropped

Behaviour:
Reset:
- Clock and reset are one clock, synchronous active-high reset.
- Reset clears the FIFO (tag_count=0, tag_full=0) and drops any in-flight result, including mid-operation.
- All outputs reset to 0: out_valid, out_x, out_y, out_angle, out_quadrant and all err_* flags.

Tag FIFO:
- Circular buffer with rd/wr pointers plus count.
- A pop occurs on every cycle with core_done=1.
- Push while full with no simultaneous pop: tag dropped, err_tag_overflow set.
- Push while full with a simultaneous pop: both succeed, count unchanged.

Tag selection on core_done:
- The tag used is the FIFO head as it stood at the start of the cycle.
- A tag pushed in the same cycle is never used for that result.
- Head empty: quadrant 0 is used, err_underrun is set, and count stays 0.

Unfold (combinational, registered on load), with q = tag, x = core_x, y = core_y:
- q0: (x, y)
- q1: (-y, x)
- q2: (-x, -y)
- q3: (y, -x)
- Negation per Optional Feature.
- out_angle = sign-extend(core_angle) + q*2^(BIT_WIDTH-1), wrapping modulo 2^(BIT_WIDTH+1).

Output register (latency 1: core_done in cycle N gives out_valid in cycle N+1):
- Load when core_done && (!out_valid || out_ready).
- out_valid && out_ready && !core_done: out_valid drops to 0 next cycle.
- out_valid && !out_ready && core_done: new result discarded, its tag is still popped (keeps alignment), err_overrun set, held data unchanged.
- Held data is stable while out_valid && !out_ready.

Error flags:
- err_* are sticky until reset.

Optional Feature:
- Macro: CORDIC_POST_SAT_EN.
- Defined: negation saturates, so -(-2^(BIT_WIDTH-1)) yields 2^(BIT_WIDTH-1)-1.
- Undefined: plain two's-complement negation, so -(-2^(BIT_WIDTH-1)) wraps to -2^(BIT_WIDTH-1).
- The angle path wraps in both cases.

Test Plan:
All scenarios use BIT_WIDTH=16, TAG_DEPTH=4.

- Push q=1, then core_done with x=1000, y=200, angle=4096 -> next cycle: out_valid=1, out_x=-200, out_y=1000, out_angle=36864, out_quadrant=1.
- Push q=3, then done with x=1000, y=200, angle=4096 -> out_x=200, out_y=-1000, out_angle=-28672 (102400 wrapped to 17 bits).
- Push q=2, then done with x=-32768, y=5 -> out_y=-5; out_x=32767 with CORDIC_POST_SAT_EN, -32768 without.
- FIFO: push 4 tags -> tag_full=1; 5th push alone -> err_tag_overflow=1, count=4; push+done same cycle when full -> count stays 4, correct FIFO order of the next 4 results.
- Hold out_ready=0 with out_valid=1, then core_done -> output unchanged, err_overrun=1, tag_count decremented by 1. Then out_ready=1 -> out_valid=0 next cycle.
- core_done with empty FIFO and simultaneous push q=2 -> result uses q=0, err_underrun=1, tag_count=1. Assert reset mid-stream -> all outputs and tag_count = 0 on the following cycle.

Source files
------------

// File: rtl/cordic_quadrant_post.sv
// -----------------------------------------------------------------------------
// cordic_quadrant_post
//
// Post-processing stage behind a pipelined CORDIC core that only works in
// quadrant I. Upstream argument reduction pushes a 2-bit quadrant tag for every
// core start. This block queues those tags in order and pairs the oldest tag
// with each core result. It then rotates x/y back to the original quadrant,
// extends the angle to a full turn, and holds the result in a valid/ready
// output register.
//
// Parameters
//   BIT_WIDTH : width of core x/y/angle (angle units: 2^BIT_WIDTH = pi)
//   TAG_DEPTH : tag FIFO depth, power of two, >= 2
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   tag_push          : push tag_quadrant into the tag FIFO
//   tag_quadrant      : quadrant of the request, 0..3 = I..IV
//   tag_full          : FIFO holds TAG_DEPTH tags
//   tag_count         : number of tags queued
//   core_done         : core result valid this cycle (pops one tag)
//   core_x/y/angle    : signed quadrant-I core result
//   out_valid         : output register holds a result
//   out_ready         : downstream accepts the held result
//   out_x/out_y       : signed unfolded coordinates
//   out_angle         : signed full-turn angle (2^(BIT_WIDTH+1) = 2*pi)
//   out_quadrant      : tag applied to the held result
//   err_tag_overflow  : sticky, a push was dropped because the FIFO was full
//   err_underrun      : sticky, core_done arrived with no tag queued
//   err_overrun       : sticky, a result was dropped while output was stalled
//
// Build option
//   CORDIC_POST_SAT_EN : when defined, x/y negation saturates the most
//                        negative value to the most positive one instead of
//                        wrapping. The angle path always wraps.
// -----------------------------------------------------------------------------
module cordic_quadrant_post #(
    parameter int BIT_WIDTH = 32,
    parameter int TAG_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  tag_push,
    input  logic [1:0]                            tag_quadrant,
    output logic                                  tag_full,
    output logic [$clog2(TAG_DEPTH):0]            tag_count,
    input  logic                                  core_done,
    input  logic signed [BIT_WIDTH-1:0]           core_x,
    input  logic signed [BIT_WIDTH-1:0]           core_y,
    input  logic signed [BIT_WIDTH-1:0]           core_angle,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [BIT_WIDTH-1:0]           out_x,
    output logic signed [BIT_WIDTH-1:0]           out_y,
    output logic signed [BIT_WIDTH:0]             out_angle,
    output logic [1:0]                            out_quadrant,
    output logic                                  err_tag_overflow,
    output logic                                  err_underrun,
    output logic                                  err_overrun
);

    localparam int AW = $clog2(TAG_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(TAG_DEPTH);
    localparam logic [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    localparam logic [BIT_WIDTH-1:0] MOST_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};

    // Two's-complement negation; the only special case is the most negative value.
    function automatic logic [BIT_WIDTH-1:0] f_neg(input logic [BIT_WIDTH-1:0] a);
        logic [BIT_WIDTH-1:0] res;
        res = -a;
`ifdef CORDIC_POST_SAT_EN
        if (a == MOST_NEG) begin
            res = MOST_POS;
        end else begin
            res = -a;
        end
`endif
        return res;
    endfunction

    // Tag FIFO state
    logic [1:0]     r_mem [TAG_DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_full;

    // Output register state
    logic                   r_out_valid;
    logic [BIT_WIDTH-1:0]   r_out_x;
    logic [BIT_WIDTH-1:0]   r_out_y;
    logic [BIT_WIDTH:0]     r_out_angle;
    logic [1:0]             r_out_quadrant;
    logic                   r_err_tag_overflow;
    logic                   r_err_underrun;
    logic                   r_err_overrun;

    // Combinational helpers
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_push_ok;
    logic [1:0]             w_head_q;
    logic [CW-1:0]          w_count_nxt;
    logic                   w_load;
    logic [BIT_WIDTH-1:0]   w_ux;
    logic [BIT_WIDTH-1:0]   w_uy;
    logic [BIT_WIDTH:0]     w_angle_ext;
    logic [BIT_WIDTH:0]     w_angle_off;
    logic [BIT_WIDTH:0]     w_uangle;

    // FIFO control: a pop needs a queued tag, a push into a full FIFO only
    // succeeds when a pop frees the head slot in the same cycle.
    always_comb begin
        w_empty   = (r_count == CNT_ZERO);
        w_pop     = core_done & ~w_empty;
        w_push_ok = tag_push & (~r_full | w_pop);
        // Head as it stood at the start of the cycle; an empty FIFO reads as quadrant I.
        if (w_empty) begin
            w_head_q = 2'd0;
        end else begin
            w_head_q = r_mem[r_rd_ptr];
        end
        if (w_push_ok && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push_ok && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
        w_load = core_done & (~r_out_valid | out_ready);
    end

    // Quadrant unfold of x/y and extension of the angle to a full turn.
    always_comb begin
        w_ux = core_x;
        w_uy = core_y;
        case (w_head_q)
            2'd0: begin
                w_ux = core_x;
                w_uy = core_y;
            end
            2'd1: begin
                w_ux = f_neg(core_y);
                w_uy = core_x;
            end
            2'd2: begin
                w_ux = f_neg(core_x);
                w_uy = f_neg(core_y);
            end
            2'd3: begin
                w_ux = core_y;
                w_uy = f_neg(core_x);
            end
            default: begin
                w_ux = core_x;
                w_uy = core_y;
            end
        endcase
        // q * pi/2 is q placed just above the (BIT_WIDTH-1) fraction bits;
        // the sum wraps naturally in BIT_WIDTH+1 bits.
        w_angle_ext = {core_angle[BIT_WIDTH-1], core_angle};
        w_angle_off = {w_head_q, {(BIT_WIDTH-1){1'b0}}};
        w_uangle    = w_angle_ext + w_angle_off;
    end

    // Tag storage write port; stale entries are harmless because reset clears the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok && !reset) begin
            r_mem[r_wr_ptr] <= tag_quadrant;
        end
    end

    // FIFO pointers, occupancy and full flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= {AW{1'b0}};
            r_wr_ptr <= {AW{1'b0}};
            r_count  <= CNT_ZERO;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_DEPTH);
        end
    end

    // Output register: load when empty or draining, hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_x        <= {BIT_WIDTH{1'b0}};
            r_out_y        <= {BIT_WIDTH{1'b0}};
            r_out_angle    <= {(BIT_WIDTH+1){1'b0}};
            r_out_quadrant <= 2'd0;
        end else if (w_load) begin
            r_out_valid    <= 1'b1;
            r_out_x        <= w_ux;
            r_out_y        <= w_uy;
            r_out_angle    <= w_uangle;
            r_out_quadrant <= w_head_q;
        end else if (r_out_valid && out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_tag_overflow <= 1'b0;
            r_err_underrun     <= 1'b0;
            r_err_overrun      <= 1'b0;
        end else begin
            if (tag_push && !w_push_ok) begin
                r_err_tag_overflow <= 1'b1;
            end
            if (core_done && w_empty) begin
                r_err_underrun <= 1'b1;
            end
            if (core_done && r_out_valid && !out_ready) begin
                r_err_overrun <= 1'b1;
            end
        end
    end

    assign tag_full         = r_full;
    assign tag_count        = r_count;
    assign out_valid        = r_out_valid;
    assign out_x            = r_out_x;
    assign out_y            = r_out_y;
    assign out_angle        = r_out_angle;
    assign out_quadrant     = r_out_quadrant;
    assign err_tag_overflow = r_err_tag_overflow;
    assign err_underrun     = r_err_underrun;
    assign err_overrun      = r_err_overrun;

endmodule

// File: tb/tb_cordic_quadrant_post.sv
module tb_cordic_quadrant_post;

    localparam int BW    = 16;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 tag_push;
    logic [1:0]           tag_quadrant;
    logic                 tag_full;
    logic [2:0]           tag_count;
    logic                 core_done;
    logic signed [BW-1:0] core_x, core_y, core_angle;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [BW-1:0] out_x, out_y;
    logic signed [BW:0]   out_angle;
    logic [1:0]           out_quadrant;
    logic                 err_tag_overflow, err_underrun, err_overrun;

    cordic_quadrant_post #(.BIT_WIDTH(BW), .TAG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .tag_push(tag_push), .tag_quadrant(tag_quadrant),
        .tag_full(tag_full), .tag_count(tag_count),
        .core_done(core_done), .core_x(core_x), .core_y(core_y), .core_angle(core_angle),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_angle(out_angle), .out_quadrant(out_quadrant),
        .err_tag_overflow(err_tag_overflow), .err_underrun(err_underrun), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int a;
        int q;
    } exp_t;

    // Reference model state (committed after each clock edge)
    int   m_tags[$];
    exp_t exp_q[$];
    bit   m_valid, m_of, m_uf, m_or;
    bit   mon_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int neg(input int v);
`ifdef CORDIC_POST_SAT_EN
        if (v == -32768) return 32767;
`else
        if (v == -32768) return -32768;
`endif
        return -v;
    endfunction

    // Full-circle result from the folded core output, in plain integer arithmetic.
    function automatic exp_t mk(input int q, input int x, input int y, input int a);
        exp_t e;
        int ang;
        case (q)
            0: begin e.x = x;      e.y = y;      end
            1: begin e.x = neg(y); e.y = x;      end
            2: begin e.x = neg(x); e.y = neg(y); end
            default: begin e.x = y; e.y = neg(x); end
        endcase
        ang = a + q * 32768;
        ang = ((ang % 131072) + 131072) % 131072;
        if (ang >= 65536) ang = ang - 131072;
        e.a = ang;
        e.q = q;
        return e;
    endfunction

    // One clock of stimulus; model consequences are committed after the edge.
    task automatic step(input bit p, input int q, input bit d,
                        input int x, input int y, input int a, input bit rdy);
        int  p_tags[$];
        int  sz, qsel, tmp;
        bit  head_empty, popped, pv, p_of, p_uf, p_or;
        tag_push     = p;
        tag_quadrant = q[1:0];
        core_done    = d;
        core_x       = x[BW-1:0];
        core_y       = y[BW-1:0];
        core_angle   = a[BW-1:0];
        out_ready    = rdy;
        p_tags = m_tags;
        sz = m_tags.size();
        head_empty = (sz == 0);
        qsel = head_empty ? 0 : m_tags[0];
        popped = 1'b0;
        p_of = 1'b0; p_uf = 1'b0; p_or = 1'b0;
        if (d) begin
            if (head_empty) p_uf = 1'b1;
            else begin tmp = p_tags.pop_front(); popped = 1'b1; end
        end
        if (p) begin
            if (sz == DEPTH && !popped) p_of = 1'b1;
            else p_tags.push_back(q);
        end
        pv = m_valid;
        if (d) begin
            if (!m_valid || rdy) begin
                exp_q.push_back(mk(qsel, x, y, a));
                pv = 1'b1;
            end else begin
                p_or = 1'b1;
            end
        end else if (m_valid && rdy) begin
            pv = 1'b0;
        end
        @(posedge clk);
        #1;
        m_tags  = p_tags;
        m_valid = pv;
        m_of |= p_of;
        m_uf |= p_uf;
        m_or |= p_or;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 0, 1'b0, 0, 0, 0, rdy);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tag_push = 1'b0; core_done = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        m_tags.delete();
        exp_q.delete();
        m_valid = 1'b0; m_of = 1'b0; m_uf = 1'b0; m_or = 1'b0;
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_x"}, int'(out_x), 0);
        chk({tag, "_y"}, int'(out_y), 0);
        chk({tag, "_angle"}, int'(out_angle), 0);
        chk({tag, "_quad"}, int'(out_quadrant), 0);
        chk({tag, "_count"}, int'(tag_count), 0);
        chk({tag, "_full"}, int'(tag_full), 0);
        chk({tag, "_errs"}, int'({err_tag_overflow, err_underrun, err_overrun}), 0);
    endtask

    // Monitor: compares status every cycle and the held result while valid;
    // retires the expected entry on each accepted handshake.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            chk("mon_valid", int'(out_valid), int'(m_valid));
            chk("mon_count", int'(tag_count), m_tags.size());
            chk("mon_full", int'(tag_full), int'(m_tags.size() == DEPTH));
            chk("mon_err_of", int'(err_tag_overflow), int'(m_of));
            chk("mon_err_uf", int'(err_underrun), int'(m_uf));
            chk("mon_err_or", int'(err_overrun), int'(m_or));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_result", 1, 0);
                end else begin
                    e = exp_q[0];
                    chk("mon_x", int'(out_x), e.x);
                    chk("mon_y", int'(out_y), e.y);
                    chk("mon_angle", int'(out_angle), e.a);
                    chk("mon_quad", int'(out_quadrant), e.q);
                    if (out_ready) e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        tag_push = 1'b0; tag_quadrant = 2'd0; core_done = 1'b0;
        core_x = '0; core_y = '0; core_angle = '0; out_ready = 1'b0;
        @(posedge clk);
        do_reset();
        chk_all_zero("reset");
        mon_en = 1'b1;

        // Quadrant II
        step(1'b1, 1, 1'b0, 0, 0, 0, 1'b0);
        step(1'b0, 0, 1'b1, 1000, 200, 4096, 1'b0);
        chk("q1_x", int'(out_x), -200);
        chk("q1_y", int'(out_y), 1000);
        chk("q1_angle", int'(out_angle), 36864);
        chk("q1_quad", int'(out_quadrant), 1);
        idle(1'b1);
        // Quadrant IV with angle wrap
        step(1'b1, 3, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1000, 200, 4096, 1'b0);
        chk("q3_x", int'(out_x), 200);
        chk("q3_y", int'(out_y), -1000);
        chk("q3_angle", int'(out_angle), -28672);
        idle(1'b1);
        // Quadrant III with most-negative x
        step(1'b1, 2, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 1'b1, -32768, 5, 0, 1'b0);
        chk("q2_y", int'(out_y), -5);
`ifdef CORDIC_POST_SAT_EN
        chk("q2_x_sat", int'(out_x), 32767);
`else
        chk("q2_x_wrap", int'(out_x), -32768);
`endif
        idle(1'b1);

        // FIFO full, overflow, push+pop while full, then order
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b0, 0, 0, 0, 1'b1);
        chk("fifo_full", int'(tag_full), 1);
        step(1'b1, 1, 1'b0, 0, 0, 0, 1'b1);
        chk("fifo_overflow", int'(err_tag_overflow), 1);
        chk("fifo_count4", int'(tag_count), 4);
        step(1'b1, 2, 1'b1, 11, 22, 33, 1'b1);
        chk("fifo_pushpop_count", int'(tag_count), 4);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 100 + i, -50 - i, 1000 * i, 1'b1);
        chk("fifo_order_last_quad", int'(out_quadrant), 2);
        idle(1'b1);

        // Overrun while stalled
        step(1'b1, 1, 1'b0, 0, 0, 0, 1'b1);
        step(1'b1, 2, 1'b0, 0, 0, 0, 1'b1);
        step(1'b0, 0, 1'b1, 300, 400, 500, 1'b0);
        step(1'b0, 0, 1'b1, 7, 8, 9, 1'b0);
        chk("ovr_err", int'(err_overrun), 1);
        chk("ovr_count", int'(tag_count), 0);
        chk("ovr_held_quad", int'(out_quadrant), 1);
        chk("ovr_held_x", int'(out_x), -400);
        idle(1'b1);
        chk("ovr_drain_valid", int'(out_valid), 0);

        // Underrun with simultaneous push
        step(1'b1, 2, 1'b1, 123, 456, 789, 1'b1);
        chk("udr_quad", int'(out_quadrant), 0);
        chk("udr_err", int'(err_underrun), 1);
        chk("udr_count", int'(tag_count), 1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) != 0),
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768,
                 1'($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream
        step(1'b1, 3, 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1, 1'b1, 9, 9, 9, 1'b0);
        do_reset();
        chk_all_zero("midreset");
        idle(1'b1);
        idle(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
